// File: rtl/mant_mul_seq_24.sv
// mant_mul_seq_24 -- sequential shift-add multiplier for two 24-bit
// single-precision significands (hidden bit included), producing the
// full 48-bit unsigned product. One partial product is added per clock.
// The accumulator update goes through a 48-bit adder made of two chained
// 24-bit segments with carry-in tied to 0.
//
// Optional build macro: EARLY_TERM_EN
//   defined   -> RUN ends as soon as the remaining multiplier bits are all
//                zero. Latency is (msb index of b)+1 edges, or 1 edge for b=0.
//   undefined -> fixed 24-edge latency.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_valid  in   operands a/b valid
//   in_ready  out  high in IDLE only
//   a         in   24-bit multiplicand significand
//   b         in   24-bit multiplier significand
//   out_valid out  product valid (DONE state)
//   out_ready in   downstream accepts product
//   p         out  48-bit product; meaningful only while out_valid
//   busy      out  state != IDLE
//
// Only WIDTH=24 is supported because the product adder is 2x24 bits.
module mant_mul_seq_24 #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplr_q,  mplr_d;
  logic [PW-1:0]     acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // 48-bit adder: two 24-bit segments, low carry feeds the high segment.
  logic [PW-1:0]    addend;
  logic [WIDTH:0]   sum_lo, sum_hi;
  logic [PW-1:0]    sum;
  logic             add_cout;

  always_comb begin
    addend   = mplr_q[0] ? mcand_q : '0;
    sum_lo   = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, addend[WIDTH-1:0]};
    sum_hi   = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend[PW-1:WIDTH]}
             + {{WIDTH{1'b0}}, sum_lo[WIDTH]};
    sum      = {sum_hi[WIDTH-1:0], sum_lo[WIDTH-1:0]};
    add_cout = sum_hi[WIDTH];
  end

  // Final iteration of RUN: counter reached the last bit, or (early-term)
  // no set multiplier bits remain after this shift.
  logic last_iter;
  always_comb begin
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef EARLY_TERM_EN
    last_iter = last_iter || ((mplr_q >> 1) == '0);
`endif
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state; DONE holds everything so p stays stable.
  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        mcand_d = {{WIDTH{1'b0}}, a};
        mplr_d  = b;
        acc_d   = '0;
        cnt_d   = '0;
      end
      RUN: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign p = acc_q;

  // A 24x24 product always fits in 48 bits, so the adder never carries out.
  a_no_cout: assert property (@(posedge clk) disable iff (rst)
                              (state_q == RUN) |-> !add_cout);

endmodule

// File: tb/tb_mant_mul_seq_24.sv
module tb_mant_mul_seq_24;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [23:0] a, b;
  logic [47:0] p;

  logic rand_bp, or_fix, or_rnd;
  assign out_ready = rand_bp ? or_rnd : or_fix;

  mant_mul_seq_24 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] prod;
    int          acc_cyc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic product and latency from the rules.
  function automatic logic [47:0] model_prod(input logic [23:0] x, input logic [23:0] y);
    longint unsigned r;
    r = longint'(x) * longint'(y);
    return r[47:0];
  endfunction

  function automatic int model_lat(input logic [23:0] y);
`ifdef EARLY_TERM_EN
    int msb;
    msb = 0;
    for (int i = 0; i < 24; i++) if (y[i]) msb = i;
    return msb + 1;
`else
    return (y == 24'd0) ? 24 : 24;
`endif
  endfunction

  always @(negedge clk) or_rnd <= 1'($urandom_range(0, 1));

  // Issue one operation; push expectation if push=1.
  task automatic issue(input logic [23:0] x, input logic [23:0] y, input bit push);
    int w;
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      chk("accept_timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) sb.push_back('{model_prod(x, y), cyc, model_lat(y)});
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || !in_ready) && w < 300) begin
      @(negedge clk);
      #2;
      w++;
    end
    if (w >= 300) chk("drain_timeout", 1, 0);
  endtask

  // Monitor: samples just after the negedge, i.e. the values the next
  // rising edge will see.
  initial begin
    bit prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst !== 1'b0) begin
        prev_ov = 1'b0;
      end else begin
        if (busy && !out_valid) chk("adder_cout", 64'(dut.add_cout), 0);
        chk("busy_vs_ready", 64'(busy), 64'(!in_ready));
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            if (!prev_ov) chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
            chk("product", p, 64'(sb[0].prod));
            chk("in_ready_while_done", 64'(in_ready), 0);
            if (out_ready) void'(sb.pop_front());
          end
          prev_ov = out_valid && !out_ready;
        end else begin
          prev_ov = 1'b0;
        end
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    or_fix = 1'b1; rand_bp = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_busy",      64'(busy), 0);
    chk("rst_p",         p, 0);

    // Reset and in_valid on the same edge: reset wins
    in_valid = 1'b1; a = 24'd5; b = 24'd5;
    @(posedge clk); #1;
    chk("rst_wins_busy", 64'(busy), 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // Boundary and directed products
    issue(24'hFFFFFF, 24'hFFFFFF, 1);
    issue(24'h800000, 24'h800000, 1);
    issue(24'hC00000, 24'hA00000, 1);
    drain();

    // Backpressure with a second request attempted during DONE
    or_fix = 1'b0;
    issue(24'h123456, 24'h000003, 1);
    w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) chk("bp_wait_timeout", 1, 0);
    in_valid = 1'b1; a = 24'd7; b = 24'd7;
    repeat (5) @(negedge clk);
    in_valid = 1'b0; or_fix = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_hs", 64'(in_ready), 1);
    chk("no_accept_in_done", 64'(busy), 0);

    // Reset mid-RUN: no output, back to reset values
    issue(24'hABCDEF, 24'h123457, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready",  64'(in_ready), 1);
    chk("midrst_busy",      64'(busy), 0);
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_p",         p, 0);
    issue(24'd3, 24'd5, 1);
    drain();

    // Early-termination-sensitive operands (24 edges when the macro is off)
    issue(24'h5A5A5A, 24'h000000, 1);
    issue(24'h000000, 24'h3C3C3C, 1);
    issue(24'h123456, 24'h000001, 1);
    issue(24'h654321, 24'h800000, 1);
    drain();

    // Random operands with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++)
      issue(24'($urandom), 24'($urandom >> $urandom_range(8, 31)), 1);
    drain();
    rand_bp = 1'b0;

    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
